car_safety_controller: RTL
==========================

CAR_SAFETY_CONTROLLER -- requirements
Module: car_safety_controller

Interface
REQ-001 Parameter VMAX, 5.0, real speed ceiling above which acceleration SHALL NOT be commanded.
REQ-002 Parameter DWELL, 4, minimum cycles spent in STOPPED before a restart SHALL be accepted.
REQ-003 clk  input  1  single clock, all state on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 nondet_A  input  real  candidate max acceleration, sampled in INIT.
REQ-006 nondet_B  input  real  candidate max braking, sampled in INIT.
REQ-007 nondet_m  input  real  candidate stop-line position, sampled in INIT and on restart.
REQ-008 req  input  2  driver request: 00 accelerate, 01 coast, 1x brake.
REQ-009 go  input  1  restart request, valid only in STOPPED.
REQ-010 x  input  real  plant position feedback.
REQ-011 v  input  real  plant velocity feedback.
REQ-012 a  output  real  commanded acceleration to the downstream car model.
REQ-013 state  output  2  INIT=00, CRUISE=01, BRAKE=10, STOPPED=11.
REQ-014 overrides  output  8  saturating count of forced brake entries.

Function
REQ-015 Sanitisation SHALL apply to every sampled real: if NaN, Inf, or <= 0 (for m: < 0), the value SHALL be replaced by 0.1 (m: 0.0); results latched into internal A, B, m.
REQ-016 INIT SHALL last exactly one cycle: latch A, B, m; output a=0.0; go to CRUISE.
REQ-017 Safety predicate safe = (x + v*v/(2*B) + (A/B + 1.0)*(A/2.0 + v) < m), evaluated combinationally on current inputs.
REQ-018 CRUISE: req=00, v <= VMAX, safe -> a <= A; req=01, safe -> a <= 0.0; otherwise a <= -B.
REQ-019 CRUISE -> BRAKE SHALL occur on the same edge that !safe is observed, and overrides SHALL increment (saturating at 255) only if req != 1x on that cycle.
REQ-020 Voluntary brake (req=1x while safe) SHALL output -B but remain in CRUISE and SHALL NOT count.
REQ-021 BRAKE: a <= -B every cycle regardless of req; BRAKE -> STOPPED when v <= B (next plant step reaches zero or clamps).
REQ-022 STOPPED: a <= 0.0; dwell counter starts at 0 on entry, increments each cycle, saturates at DWELL.
REQ-023 STOPPED -> CRUISE only when go=1 and dwell counter == DWELL; on that edge m SHALL be resampled and sanitised per REQ-015, dwell cleared.
REQ-024 go=1 before dwell complete SHALL be ignored (not queued).
REQ-025 a SHALL always equal exactly one of {A, 0.0, -B}.
REQ-026 Plant inputs x, v that are NaN/Inf SHALL be treated as !safe (forced brake path).
REQ-027 One-cycle latency: a and state registered; no combinational path from inputs to a.

Reset
REQ-028 On rst assertion (asynchronous, any time incl. mid-BRAKE): state=INIT, a=0.0, overrides=0, dwell=0, A=B=0.1, m=0.0 immediately.
REQ-029 Deassertion SHALL resume at INIT with fresh sampling on the first clk edge.
REQ-030 Formal properties SHALL be included, gated by rst: a in {A,0,-B}; state==BRAKE -> a==-B; state==STOPPED -> a==0.0; A>0 && B>0 outside INIT; overrides never decreases except on rst.

Verification
REQ-031 nondet_A=NaN, nondet_B=-3.0, nondet_m=100.0 at INIT -> A=0.1, B=0.1, m=100.0, state CRUISE next cycle.
REQ-032 A=1.0, B=2.0, m=100.0, x=0, v=2, req=00 -> a=1.0; same with v=6.0 -> a=-2.0, state CRUISE, overrides unchanged.
REQ-033 A=1.0, B=2.0, m=10.0, x=8.0, v=3.0, req=00 -> unsafe, state BRAKE, a=-2.0, overrides 0 -> 1; v=1.5 next -> STOPPED, a=0.0.
REQ-034 STOPPED, go=1 at dwell 2 -> stays STOPPED; go=1 at dwell 4 with nondet_m=200.0 -> CRUISE, m=200.0.
REQ-035 300 forced brake entries -> overrides saturates at 255.
REQ-036 rst pulsed between clock edges during BRAKE -> a=0.0, state=INIT, overrides=0 without waiting for clk.

Source files
------------

// File: rtl/car_safety_controller.sv
// -----------------------------------------------------------------------------
// car_safety_controller
//
// Supervisory controller that sits between a driver request and a longitudinal
// car model. It latches the car's acceleration/braking capability and a
// stop-line position, then only passes acceleration through while the car can
// still stop before the line. If it cannot, the controller forces full braking
// until the car has (almost) stopped. It then holds the car for a minimum dwell
// time before it accepts a restart.
//
// Ports
//   clk        in   1     single clock, all state changes on posedge
//   rst        in   1     asynchronous, active-high reset
//   nondet_A   in   real  candidate max acceleration, sampled in INIT
//   nondet_B   in   real  candidate max braking, sampled in INIT
//   nondet_m   in   real  candidate stop-line position, sampled in INIT/restart
//   req        in   2     driver request: 00 accelerate, 01 coast, 1x brake
//   go         in   1     restart request, honoured only in STOPPED
//   x          in   real  plant position feedback
//   v          in   real  plant velocity feedback
//   a          out  real  registered acceleration command, always A, 0.0 or -B
//   state      out  2     INIT=00, CRUISE=01, BRAKE=10, STOPPED=11
//   overrides  out  8     saturating count of forced brake entries
// -----------------------------------------------------------------------------
module car_safety_controller #(
  parameter real VMAX  = 5.0,
  parameter int  DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  real        nondet_A,
  input  real        nondet_B,
  input  real        nondet_m,
  input  logic [1:0] req,
  input  logic       go,
  input  real        x,
  input  real        v,
  output real        a,
  output logic [1:0] state,
  output logic [7:0] overrides
);

  typedef enum logic [1:0] {
    INIT    = 2'b00,
    CRUISE  = 2'b01,
    BRAKE   = 2'b10,
    STOPPED = 2'b11
  } state_t;

  localparam int              DW        = $clog2(DWELL + 1);
  localparam logic [DW-1:0]   DWELL_MAX = DW'(DWELL);
  // An IEEE-754 double whose exponent field is all ones is Inf or NaN.
  localparam logic [63:0]     EXP_MASK  = 64'h7FF0_0000_0000_0000;

  state_t        state_q;
  real           a_max;      // latched, sanitised max acceleration A
  real           b_max;      // latched, sanitised max braking B
  real           m_stop;     // latched, sanitised stop-line position m
  logic [DW-1:0] dwell;
  logic          safe;

  function automatic logic is_finite(input real r);
    return ($realtobits(r) & EXP_MASK) != EXP_MASK;
  endfunction

  // Rates must be strictly positive; anything unusable falls back to 0.1.
  function automatic real clean_rate(input real r);
    return (!is_finite(r) || r <= 0.0) ? 0.1 : r;
  endfunction

  // The stop line may sit at the origin; unusable values fall back to 0.0.
  function automatic real clean_line(input real r);
    return (!is_finite(r) || r < 0.0) ? 0.0 : r;
  endfunction

  // Worst case: one more cycle of full acceleration, then full braking. The car
  // is safe if that stopping point still lies before the stop line. A NaN
  // anywhere in the sum makes the comparison false, so bad feedback brakes.
  always_comb begin
    safe = is_finite(x) && is_finite(v) &&
           (x + v * v / (2.0 * b_max) +
            (a_max / b_max + 1.0) * (a_max / 2.0 + v) < m_stop);
  end

  assign state = state_q;

  // NOTE: every register here is written with <= so that all of them see the
  // pre-edge values of each other; blocking writes would make the result
  // depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= INIT;
      a         <= 0.0;
      overrides <= '0;
      dwell     <= '0;
      a_max     <= 0.1;
      b_max     <= 0.1;
      m_stop    <= 0.0;
    end else begin
      case (state_q)
        INIT: begin
          a_max   <= clean_rate(nondet_A);
          b_max   <= clean_rate(nondet_B);
          m_stop  <= clean_line(nondet_m);
          a       <= 0.0;
          state_q <= CRUISE;
        end

        CRUISE: begin
          if (!safe) begin
            state_q <= BRAKE;
            a       <= -b_max;
            // Only count it as an override when the driver was not already
            // asking to brake.
            if (!req[1] && overrides != 8'hFF) overrides <= overrides + 8'd1;
          end else if (req == 2'b00 && v <= VMAX) begin
            a <= a_max;
          end else if (req == 2'b01) begin
            a <= 0.0;
          end else begin
            a <= -b_max;  // voluntary brake, or accelerate above VMAX
          end
        end

        BRAKE: begin
          // One more braking step brings v to zero (or the plant clamps it).
          if (v <= b_max) begin
            state_q <= STOPPED;
            a       <= 0.0;
            dwell   <= '0;
          end else begin
            a <= -b_max;
          end
        end

        STOPPED: begin
          a <= 0.0;
          // A go seen before the dwell completes is dropped, not remembered.
          if (go && dwell == DWELL_MAX) begin
            state_q <= CRUISE;
            m_stop  <= clean_line(nondet_m);
            dwell   <= '0;
          end else if (dwell != DWELL_MAX) begin
            dwell <= dwell + 1'b1;
          end
        end

        default: state_q <= INIT;
      endcase
    end
  end

  // Previous overrides value, used only to check that the count is monotonic.
  logic [7:0] overrides_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrides_seen <= '0;
    else     overrides_seen <= overrides;
  end

  // Safety invariants, sampled on the clock while reset is released.
  always @(posedge clk) begin
    if (!rst) begin
      assert (a == a_max || a == 0.0 || a == -b_max)
        else $error("a is not one of {A, 0.0, -B}");
      assert (state_q != BRAKE || a == -b_max)
        else $error("BRAKE without a == -B");
      assert (state_q != STOPPED || a == 0.0)
        else $error("STOPPED without a == 0.0");
      assert (state_q == INIT || (a_max > 0.0 && b_max > 0.0))
        else $error("non-positive A or B outside INIT");
      assert (overrides >= overrides_seen)
        else $error("overrides decreased without reset");
    end
  end

endmodule
